// File: rtl/jtdsp16_sio_pkg.sv
// Shared constants and types for the DSP16 serial-output receiver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: word/address widths, bit-counter width, packed word+address record.
package jtdsp16_sio_pkg;

  localparam int SIO_WORD_W    = 16;
  localparam int SIO_ADDR_W    = 8;
  localparam int SIO_ADDR_BITS = 8;
  // Counter must represent 0..SIO_WORD_W.
  localparam int SIO_CNT_W     = $clog2(SIO_WORD_W + 1);

  typedef struct packed {
    logic [SIO_ADDR_W-1:0] addr;
    logic [SIO_WORD_W-1:0] data;
  } sio_word_t;

endpackage

// File: rtl/jtdsp16_sio_deser.sv
// Deserialiser: ock edge detect, data/address shift registers, bit counter, abort.
// Latency: done is combinational in the cen cycle that samples the 16th bit.
// Backpressure: none; done pulses regardless of downstream state.
// Ports: clk, rst_n (sync, active-low), cen; serial ock/sdi/old/sadd in;
//        done (1-cycle), dout (word+addr, valid with done), abort (1-cycle), busy.
module jtdsp16_sio_deser
  import jtdsp16_sio_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      cen,
  input  logic      ock,
  input  logic      sdi,
  input  logic      old,
  input  logic      sadd,
  output logic      done,
  output sio_word_t dout,
  output logic      abort,
  output logic      busy
);

  logic                  last_ock;
  logic [SIO_WORD_W-1:0] sr;
  logic [SIO_ADDR_W-1:0] ar;
  logic [SIO_CNT_W-1:0]  cnt;
  logic                  sample;

  assign sample = cen && ock && !last_ock && !old;
  assign done   = sample && (cnt == SIO_CNT_W'(SIO_WORD_W - 1));
  // The 16th bit is folded in here so the word is usable in the done cycle.
  assign dout.data = {sr[SIO_WORD_W-2:0], sdi};
  assign dout.addr = ar;
  // sample requires old low, so abort and sample never coincide.
  assign abort  = cen && old && (cnt != '0);
  assign busy   = (cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_ock <= 1'b0;
      sr       <= '0;
      ar       <= '0;
      cnt      <= '0;
    end else if (cen) begin
      last_ock <= ock;
      if (sample) begin
        sr <= {sr[SIO_WORD_W-2:0], sdi};
        if (cnt < SIO_CNT_W'(SIO_ADDR_BITS))
          ar <= {ar[SIO_ADDR_W-2:0], sadd};
        cnt <= done ? '0 : cnt + SIO_CNT_W'(1);
      end else if (abort) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/jtdsp16_sio_rx.sv
// DSP16 serial-output receiver: word port, sticky error flags, left/right pairing.
// Latency: wvalid rises 1 clk after the cen cycle sampling the 16th ock edge (+2 clk with sync).
// Backpressure: a word completing while wvalid is held (wready low) is dropped and flags overrun.
// Ports: clk, rst_n (sync, active-low), cen; ock/sdi/old/sadd serial in;
//        word/waddr/wvalid/wready word port; left/right/pair_stb stereo;
//        overrun/frame_err sticky flags; busy frame-in-progress.
// Option: define JTDSP16_SIO_RX_SYNC_EN to add 2-flop input synchronisers.
module jtdsp16_sio_rx
  import jtdsp16_sio_pkg::*;
#(
  parameter logic [SIO_ADDR_W-1:0] LEFT_ADDR  = 8'h00,
  parameter logic [SIO_ADDR_W-1:0] RIGHT_ADDR = 8'h01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cen,
  input  logic                  ock,
  input  logic                  sdi,
  input  logic                  old,
  input  logic                  sadd,
  output logic [SIO_WORD_W-1:0] word,
  output logic [SIO_ADDR_W-1:0] waddr,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [SIO_WORD_W-1:0] left,
  output logic [SIO_WORD_W-1:0] right,
  output logic                  pair_stb,
  output logic                  overrun,
  output logic                  frame_err,
  output logic                  busy
);

  logic      ock_i, sdi_i, old_i, sadd_i;
  logic      done, abort;
  logic      load, drop, consume;
  logic      pair_flag;
  sio_word_t dw;

`ifdef JTDSP16_SIO_RX_SYNC_EN
  // Free-running on clk: the synchronisers must not stall when cen is low.
  logic [3:0] sync1, sync2;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {ock, sdi, old, sadd};
      sync2 <= sync1;
    end
  end
  assign {ock_i, sdi_i, old_i, sadd_i} = sync2;
`else
  assign {ock_i, sdi_i, old_i, sadd_i} = {ock, sdi, old, sadd};
`endif

  jtdsp16_sio_deser u_deser (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .ock   (ock_i),
    .sdi   (sdi_i),
    .old   (old_i),
    .sadd  (sadd_i),
    .done  (done),
    .dout  (dw),
    .abort (abort),
    .busy  (busy)
  );

  // done already implies cen. A word may load into a buffer being drained this cycle.
  assign load    = done && (!wvalid || wready);
  assign drop    = done && wvalid && !wready;
  assign consume = cen && wvalid && wready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word      <= '0;
      waddr     <= '0;
      wvalid    <= 1'b0;
      left      <= '0;
      right     <= '0;
      pair_stb  <= 1'b0;
      pair_flag <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // Held across non-cen clocks so the pulse spans exactly one cen cycle.
      if (cen)
        pair_stb <= 1'b0;
      if (load) begin
        word   <= dw.data;
        waddr  <= dw.addr;
        wvalid <= 1'b1;
        // Left is tested first so LEFT_ADDR==RIGHT_ADDR updates left only.
        if (dw.addr == LEFT_ADDR) begin
          left      <= dw.data;
          pair_flag <= 1'b1;
        end else if (dw.addr == RIGHT_ADDR) begin
          right <= dw.data;
          if (pair_flag) begin
            pair_stb  <= 1'b1;
            pair_flag <= 1'b0;
          end
        end
      end else if (consume) begin
        wvalid <= 1'b0;
      end
      if (drop)
        overrun <= 1'b1;
      if (abort)
        frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtdsp16_sio_rx.sv
// Testbench for jtdsp16_sio_rx: table of words with expected post-state,
// plus directed sequences for simultaneous load/consume, abort, cen gap and reset.
module tb_jtdsp16_sio_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic        ock = 1'b0;
  logic        sdi = 1'b0;
  logic        old = 1'b1;
  logic        sadd = 1'b0;
  logic        wready = 1'b1;
  logic [15:0] word, left, right;
  logic [7:0]  waddr;
  logic        wvalid, pair_stb, overrun, frame_err, busy;

`ifdef JTDSP16_SIO_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  jtdsp16_sio_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .ock       (ock),
    .sdi       (sdi),
    .old       (old),
    .sadd      (sadd),
    .word      (word),
    .waddr     (waddr),
    .wvalid    (wvalid),
    .wready    (wready),
    .left      (left),
    .right     (right),
    .pair_stb  (pair_stb),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  int          pair_cnt = 0;
  logic [15:0] acc_word = '0;
  logic [7:0]  acc_addr = '0;

  // Consumer-side scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    if (cen && wvalid && wready) begin
      acc_cnt  <= acc_cnt + 1;
      acc_word <= word;
      acc_addr <= waddr;
    end
    if (pair_stb)
      pair_cnt <= pair_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ock = 1'b0; old = 1'b0; sdi = data[15-i];
      sadd = (i < 8) ? data[7-i] : 1'b0;
      tick; tick;
      ock = 1'b1;
      tick; tick;
    end
  endtask

  // chk_lat: measure clocks from the 16th ock rise to wvalid.
  // sim: pulse wready in exactly the cycle the word completes.
  task automatic send_word(input logic [15:0] data, input logic [7:0] addr,
                           input logic chk_lat, input logic sim);
    int n;
    for (int i = 0; i < 16; i++) begin
      ock = 1'b0; old = 1'b0; sdi = data[15-i];
      sadd = (i < 8) ? addr[7-i] : ~data[15-i];
      tick; tick;
      ock = 1'b1;
      if (i == 15 && sim) begin
        repeat (LAT - 1) tick;
        wready = 1'b1;
        tick;
        wready = 1'b0;
      end else if (i == 15 && chk_lat) begin
        n = 0;
        while (!wvalid && n < 8) begin
          tick;
          n++;
        end
        chk("wvalid_latency", n, LAT);
      end else begin
        tick; tick;
      end
    end
    ock = 1'b0; old = 1'b1;
    repeat (LAT + 3) tick;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_word"}, word, 0);
    chk({pfx, "_waddr"}, waddr, 0);
    chk({pfx, "_wvalid"}, wvalid, 0);
    chk({pfx, "_left"}, left, 0);
    chk({pfx, "_right"}, right, 0);
    chk({pfx, "_pair_stb"}, pair_stb, 0);
    chk({pfx, "_overrun"}, overrun, 0);
    chk({pfx, "_frame_err"}, frame_err, 0);
    chk({pfx, "_busy"}, busy, 0);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [7:0]  addr;
    logic        rdy;
    logic        exp_vld;
    logic [15:0] exp_word;
    logic [7:0]  exp_waddr;
    logic [15:0] exp_left;
    logic [15:0] exp_right;
    int          exp_acc;
    int          exp_pairs;
    logic        exp_ovr;
  } vec_t;

  vec_t vt [12];

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      wready = vt[i].rdy;
      send_word(vt[i].data, vt[i].addr, 1'b0, 1'b0);
      chk($sformatf("row%0d_wvalid", i), wvalid, vt[i].exp_vld);
      chk($sformatf("row%0d_word", i), word, vt[i].exp_word);
      chk($sformatf("row%0d_waddr", i), waddr, vt[i].exp_waddr);
      chk($sformatf("row%0d_left", i), left, vt[i].exp_left);
      chk($sformatf("row%0d_right", i), right, vt[i].exp_right);
      chk($sformatf("row%0d_accepted", i), acc_cnt, vt[i].exp_acc);
      chk($sformatf("row%0d_pairs", i), pair_cnt, vt[i].exp_pairs);
      chk($sformatf("row%0d_overrun", i), overrun, vt[i].exp_ovr);
      chk($sformatf("row%0d_busy", i), busy, 0);
    end
  endtask

  initial begin
    //        data      addr  rdy  vld   word      waddr  left      right   acc pr ovr
    vt[0]  = '{16'hA5C3, 8'h00, 1'b1, 1'b0, 16'hA5C3, 8'h00, 16'hA5C3, 16'h0000, 1, 0, 1'b0};
    vt[1]  = '{16'h1234, 8'h00, 1'b1, 1'b0, 16'h1234, 8'h00, 16'h1234, 16'h0000, 2, 0, 1'b0};
    vt[2]  = '{16'hBEEF, 8'h01, 1'b1, 1'b0, 16'hBEEF, 8'h01, 16'h1234, 16'hBEEF, 3, 1, 1'b0};
    vt[3]  = '{16'h5555, 8'h01, 1'b1, 1'b0, 16'h5555, 8'h01, 16'h1234, 16'h5555, 4, 1, 1'b0};
    vt[4]  = '{16'h1111, 8'h00, 1'b1, 1'b0, 16'h1111, 8'h00, 16'h1111, 16'h5555, 5, 1, 1'b0};
    vt[5]  = '{16'h2222, 8'h00, 1'b1, 1'b0, 16'h2222, 8'h00, 16'h2222, 16'h5555, 6, 1, 1'b0};
    vt[6]  = '{16'h3333, 8'h01, 1'b1, 1'b0, 16'h3333, 8'h01, 16'h2222, 16'h3333, 7, 2, 1'b0};
    vt[7]  = '{16'h0F0F, 8'h42, 1'b1, 1'b0, 16'h0F0F, 8'h42, 16'h2222, 16'h3333, 8, 2, 1'b0};
    vt[8]  = '{16'h0000, 8'h01, 1'b1, 1'b0, 16'h0000, 8'h01, 16'h2222, 16'h0000, 9, 2, 1'b0};
    vt[9]  = '{16'h0001, 8'h03, 1'b0, 1'b1, 16'h0001, 8'h03, 16'h2222, 16'h0000, 11, 2, 1'b0};
    vt[10] = '{16'h0002, 8'h03, 1'b0, 1'b1, 16'h0001, 8'h03, 16'h2222, 16'h0000, 11, 2, 1'b1};
    vt[11] = '{16'h7777, 8'h00, 1'b0, 1'b1, 16'h0001, 8'h03, 16'h2222, 16'h0000, 11, 2, 1'b1};

    // Reset state
    repeat (3) tick;
    chk_zero("reset");
    rst_n = 1'b1;
    tick;

    // Single words, stereo pairing, other addresses
    run_rows(0, 8);

    // Word completes in the same cycle the previous one is consumed
    wready = 1'b0;
    send_word(16'h4444, 8'h05, 1'b0, 1'b0);
    chk("sim_first_vld", wvalid, 1);
    chk("sim_first_word", word, 16'h4444);
    chk("sim_first_acc", acc_cnt, 9);
    send_word(16'h6666, 8'h05, 1'b0, 1'b1);
    chk("sim_vld_held", wvalid, 1);
    chk("sim_new_word", word, 16'h6666);
    chk("sim_overrun", overrun, 0);
    chk("sim_acc", acc_cnt, 10);
    chk("sim_acc_word", acc_word, 16'h4444);
    wready = 1'b1;
    tick;
    chk("sim_drain_vld", wvalid, 0);
    chk("sim_drain_acc", acc_cnt, 11);
    chk("sim_drain_word", acc_word, 16'h6666);

    // Overrun: stalled consumer, dropped words
    run_rows(9, 11);
    wready = 1'b1;
    tick;
    chk("ovr_drain_vld", wvalid, 0);
    chk("ovr_drain_acc", acc_cnt, 12);
    chk("ovr_drain_word", acc_word, 16'h0001);

    // Abort after 7 bits
    send_bits(16'hFE00, 7);
    chk("abort_busy_mid", busy, 1);
    old = 1'b1;
    repeat (LAT + 2) tick;
    chk("abort_frame_err", frame_err, 1);
    chk("abort_busy", busy, 0);
    chk("abort_no_vld", wvalid, 0);
    chk("abort_no_acc", acc_cnt, 12);
    send_word(16'h8000, 8'h00, 1'b0, 1'b0);
    chk("post_abort_acc", acc_cnt, 13);
    chk("post_abort_word", acc_word, 16'h8000);
    chk("post_abort_addr", acc_addr, 8'h00);
    chk("post_abort_left", left, 16'h8000);

    // cen low: no state change, but the held ock edge is seen afterwards
    cen = 1'b0; old = 1'b0; sdi = 1'b1; ock = 1'b0;
    tick; tick;
    ock = 1'b1;
    repeat (4) tick;
    chk("cen_gap_busy", busy, 0);
    cen = 1'b1;
    tick;
    chk("cen_edge_kept", busy, 1);
    ock = 1'b0; old = 1'b1;
    repeat (LAT + 2) tick;
    chk("cen_abort_busy", busy, 0);

    // Reset mid-frame
    send_bits(16'hFFFF, 9);
    chk("rst_busy_mid", busy, 1);
    rst_n = 1'b0; old = 1'b1; ock = 1'b0;
    tick; tick;
    chk_zero("midrst");
    rst_n = 1'b1;
    tick;
    send_word(16'h7FFF, 8'h01, 1'b1, 1'b0);
    chk("post_rst_acc", acc_cnt, 14);
    chk("post_rst_word", acc_word, 16'h7FFF);
    chk("post_rst_addr", acc_addr, 8'h01);
    chk("post_rst_right", right, 16'h7FFF);
    chk("post_rst_left", left, 0);
    chk("post_rst_frame_err", frame_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
